// File: rtl/rtp_hit_collector.sv
// rtl/rtp_hit_collector.sv - round-robin hit collector with show-ahead FIFO and run counters
// Gathers per-channel hit results into one stream and reports ray/miss/cycle statistics.
module rtp_hit_collector #(
  parameter int          NUM_CH    = 4,
  parameter int          DEPTH     = 16,
  parameter logic [31:0] MISS_HITT = 32'h7F800000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   io_start,
  input  logic [31:0]            io_num_rays,
  input  logic [NUM_CH-1:0]      io_in_valid,
  output logic [NUM_CH-1:0]      io_in_ready,
  input  logic [32*NUM_CH-1:0]   io_in_hitT,
  input  logic [32*NUM_CH-1:0]   io_in_ray_id,
  output logic                   io_out_valid,
  input  logic                   io_out_ready,
  output logic [31:0]            io_out_hitT,
  output logic [31:0]            io_out_ray_id,
  output logic [3:0]             io_out_ch,
  output logic                   io_busy,
  output logic                   io_rtp_finish,
  output logic [31:0]            io_ray_count,
  output logic [31:0]            io_miss_count,
  output logic [63:0]            io_total_cycle
);

  localparam int            AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int            CW       = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [3:0]    LAST_CH  = 4'(NUM_CH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_next;

  logic [3:0]    r_ptr;
  logic [31:0]   r_num_rays;
  logic [31:0]   r_ray_count;
  logic [31:0]   r_miss_count;
  logic [63:0]   r_total_cycle;

  logic [67:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic              w_full;
  logic              w_push;
  logic              w_pop;
  logic              w_start_acc;
  logic              w_last_ray;
  logic              w_is_miss;
  logic              w_busy;
  logic              w_finish;
  logic [NUM_CH-1:0] w_in_ready;
  logic [3:0]        w_grant_idx;
  logic [3:0]        w_ptr_next;
  logic [31:0]       w_push_hitT;
  logic [31:0]       w_push_ray_id;
  logic [67:0]       w_head;
  int                w_dist;
  int                w_best;

  assign w_full      = (r_count == FULL_CNT);
  assign w_pop       = (r_count != '0) && io_out_ready;
  assign w_start_acc = io_start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last_ray  = ((r_ray_count + 32'd1) == r_num_rays);
  assign w_is_miss   = (w_push_hitT == MISS_HITT);
  assign w_ptr_next  = (w_grant_idx == LAST_CH) ? 4'd0 : (w_grant_idx + 4'd1);

  // Winner is the valid channel with the smallest forward distance from the RR pointer.
  always_comb begin
    w_push        = 1'b0;
    w_grant_idx   = '0;
    w_in_ready    = '0;
    w_push_hitT   = '0;
    w_push_ray_id = '0;
    w_dist        = 0;
    w_best        = NUM_CH;
    if ((r_state == S_RUN) && !w_full) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (io_in_valid[c]) begin
          w_dist = c - int'(r_ptr);
          if (w_dist < 0) w_dist = w_dist + NUM_CH;
          if (w_dist < w_best) begin
            w_best      = w_dist;
            w_grant_idx = 4'(c);
            w_push      = 1'b1;
          end
        end
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_push && (w_grant_idx == 4'(c))) begin
          w_in_ready[c] = 1'b1;
          w_push_hitT   = io_in_hitT[32*c +: 32];
          w_push_ray_id = io_in_ray_id[32*c +: 32];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_busy       = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (io_start) w_state_next = (io_num_rays == 32'd0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        w_busy = 1'b1;
        if (w_push && w_last_ray) w_state_next = S_DRAIN;
      end
      S_DRAIN: begin
        w_busy = 1'b1;
        if (r_count == '0) w_state_next = S_DONE;
      end
      S_DONE: begin
        w_finish = 1'b1;
        if (io_start) w_state_next = (io_num_rays == 32'd0) ? S_DONE : S_RUN;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ptr         <= '0;
      r_num_rays    <= '0;
      r_ray_count   <= '0;
      r_miss_count  <= '0;
      r_total_cycle <= '0;
    end else begin
      if (w_start_acc) begin
        r_num_rays    <= io_num_rays;
        r_ray_count   <= '0;
        r_miss_count  <= '0;
        r_total_cycle <= '0;
      end else begin
        if (w_busy) r_total_cycle <= r_total_cycle + 64'd1;
        if (w_push) begin
          r_ray_count <= r_ray_count + 32'd1;
          if (w_is_miss) r_miss_count <= r_miss_count + 32'd1;
        end
      end
      if (w_push) r_ptr <= w_ptr_next;
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= {w_push_hitT, w_push_ray_id, w_grant_idx};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Head fields read as zero while empty so stale storage never shows on the port.
  assign w_head         = r_mem[r_rd_ptr];
  assign io_out_valid   = (r_count != '0);
  assign io_out_hitT    = io_out_valid ? w_head[67:36] : '0;
  assign io_out_ray_id  = io_out_valid ? w_head[35:4]  : '0;
  assign io_out_ch      = io_out_valid ? w_head[3:0]   : '0;
  assign io_in_ready    = w_in_ready;
  assign io_busy        = w_busy;
  assign io_rtp_finish  = w_finish;
  assign io_ray_count   = r_ray_count;
  assign io_miss_count  = r_miss_count;
  assign io_total_cycle = r_total_cycle;

endmodule
